// File: rtl/ds_pkg.sv
// ds_pkg: shared constants and state encoding for the DScope frame scheduler.
// Rev 1.0
`default_nettype none

package ds_pkg;

  localparam logic [3:0] TAG_TRAILER = 4'hF;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_CH_MASK    = 3'd1;
  localparam logic [2:0] REG_TIMEOUT    = 3'd2;
  localparam logic [2:0] REG_FRAME_CNT  = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;
  localparam logic [2:0] REG_STATUS_CLR = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } ds_state_e;

endpackage

`default_nettype wire

// File: rtl/ds_next_ch.sv
// ds_next_ch: finds the lowest set mask bit at or above a start index.
// Rev 1.0
`default_nettype none

module ds_next_ch
  import ds_pkg::*;
#(
  parameter int NCH = 15
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [3:0]     start_i,
  output logic           found_o,
  output logic [3:0]     idx_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(start_i))) begin
        found_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ds_frame_sched.sv
// ds_frame_sched: drains enabled channel sources into the 36-bit tagged stream, one trailer per frame.
// Rev 1.0
`default_nettype none

module ds_frame_sched
  import ds_pkg::*;
#(
  parameter int NCH          = 15,
  parameter int WORDS_PER_CH = 32,
  parameter int TMO_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_trig,
  input  logic [NCH*32-1:0] i_ch_data,
  input  logic [NCH-1:0]    i_ch_vld,
  output logic [NCH-1:0]    o_ch_rdy,
  output logic [35:0]       o_data,
  output logic              o_vld,
  input  logic              i_rdy,
  input  logic [7:0]        i_mm_addr,
  input  logic              i_mm_wr,
  input  logic [31:0]       i_mm_wr_data,
  input  logic              i_mm_rd,
  output logic [31:0]       o_mm_rd_data
);

  ds_state_e        state_q;
  logic             enable_q;
  logic             free_run_q;
  logic [NCH-1:0]   ch_mask_q;
  logic [NCH-1:0]   shadow_q;
  logic [TMO_W-1:0] timeout_q;
  logic [TMO_W-1:0] tmo_q;
  logic [31:0]      frame_cnt_q;
  logic [31:0]      rd_data_q;
  logic [7:0]       missed_q;
  logic [7:0]       underrun_q;
  logic [7:0]       word_cnt_q;
  logic [3:0]       cur_ch_q;
  logic [3:0]       sel_ch_q;
  logic             pad_q;

  logic             w_found;
  logic [3:0]       w_idx;
  logic             w_src_vld;
  logic [31:0]      w_src_data;
  logic             w_tmo_hit;
  logic             w_pad;
  logic             w_vld;
  logic [35:0]      w_data;
  logic             w_beat;
  logic [31:0]      w_rd_mux;
  logic             w_wr_ctrl;
  logic             w_wr_mask;
  logic             w_wr_tmo;
  logic             w_clr;
  logic             w_missed_inc;

  ds_next_ch #(
    .NCH (NCH)
  ) u_next_ch (
    .mask_i  (shadow_q),
    .start_i (cur_ch_q),
    .found_o (w_found),
    .idx_o   (w_idx)
  );

  always_comb begin
    w_src_vld  = 1'b0;
    w_src_data = 32'd0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_ch_q == 4'(c)) begin
        w_src_vld  = i_ch_vld[c];
        w_src_data = i_ch_data[c*32 +: 32];
      end
    end
  end

  // The timeout hit switches to padding in the same cycle; the previous cycle had o_vld low.
  assign w_tmo_hit = (state_q == XFER) && !pad_q && (timeout_q != '0) && (tmo_q == timeout_q);
  assign w_pad     = pad_q | w_tmo_hit;

  always_comb begin
    w_vld  = 1'b0;
    w_data = 36'd0;
    case (state_q)
      XFER: begin
        w_vld  = w_pad ? 1'b1 : w_src_vld;
        w_data = {sel_ch_q, (w_pad ? 32'd0 : w_src_data)};
      end
      TRAIL: begin
        w_vld  = 1'b1;
        w_data = {TAG_TRAILER, frame_cnt_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ch_rdy = '0;
    for (int c = 0; c < NCH; c++) begin
      o_ch_rdy[c] = (state_q == XFER) && !w_pad && (sel_ch_q == 4'(c)) && i_rdy;
    end
  end

  assign o_vld        = w_vld;
  assign o_data       = w_data;
  assign o_mm_rd_data = rd_data_q;
  assign w_beat       = w_vld && i_rdy;

  assign w_wr_ctrl    = i_mm_wr && (i_mm_addr[2:0] == REG_CTRL);
  assign w_wr_mask    = i_mm_wr && (i_mm_addr[2:0] == REG_CH_MASK);
  assign w_wr_tmo     = i_mm_wr && (i_mm_addr[2:0] == REG_TIMEOUT);
  assign w_clr        = i_mm_wr && (i_mm_addr[2:0] == REG_STATUS_CLR);
  assign w_missed_inc = i_trig && (state_q != IDLE);

  always_comb begin
    w_rd_mux = 32'd0;
    case (i_mm_addr[2:0])
      REG_CTRL:      w_rd_mux = {30'd0, free_run_q, enable_q};
      REG_CH_MASK:   w_rd_mux = 32'(ch_mask_q);
      REG_TIMEOUT:   w_rd_mux = 32'(timeout_q);
      REG_FRAME_CNT: w_rd_mux = frame_cnt_q;
      REG_STATUS:    w_rd_mux = {missed_q, underrun_q, 11'd0, (state_q != IDLE), cur_ch_q};
      default:       w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      free_run_q  <= 1'b0;
      ch_mask_q   <= '0;
      shadow_q    <= '0;
      timeout_q   <= '0;
      tmo_q       <= '0;
      frame_cnt_q <= 32'd0;
      rd_data_q   <= 32'd0;
      missed_q    <= 8'd0;
      underrun_q  <= 8'd0;
      word_cnt_q  <= 8'd0;
      cur_ch_q    <= 4'd0;
      sel_ch_q    <= 4'd0;
      pad_q       <= 1'b0;
    end else begin
      if (i_mm_rd) rd_data_q <= w_rd_mux;
      if (w_wr_ctrl) begin
        enable_q   <= i_mm_wr_data[0];
        free_run_q <= i_mm_wr_data[1];
      end
      if (w_wr_mask) ch_mask_q <= i_mm_wr_data[NCH-1:0];
      if (w_wr_tmo)  timeout_q <= i_mm_wr_data[TMO_W-1:0];

      if (w_clr)                                  missed_q <= 8'd0;
      else if (w_missed_inc && missed_q != 8'hFF) missed_q <= missed_q + 8'd1;

      if (w_clr)                                     underrun_q <= 8'd0;
      else if (w_tmo_hit && underrun_q != 8'hFF)     underrun_q <= underrun_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (enable_q && i_trig) begin
            shadow_q <= ch_mask_q;
            cur_ch_q <= 4'd0;
            state_q  <= SEL;
          end
        end
        SEL: begin
          if (w_found) begin
            sel_ch_q   <= w_idx;
            word_cnt_q <= 8'd0;
            tmo_q      <= '0;
            pad_q      <= 1'b0;
            state_q    <= XFER;
          end else begin
            state_q <= TRAIL;
          end
        end
        XFER: begin
          if (w_tmo_hit) pad_q <= 1'b1;
          if (w_beat) begin
            tmo_q <= '0;
            if (word_cnt_q == 8'(WORDS_PER_CH - 1)) begin
              cur_ch_q <= sel_ch_q + 4'd1;
              state_q  <= SEL;
            end else begin
              word_cnt_q <= word_cnt_q + 8'd1;
            end
          end else if (!w_pad && !w_src_vld) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        TRAIL: begin
          if (i_rdy) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (free_run_q && enable_q) begin
              shadow_q <= ch_mask_q;
              cur_ch_q <= 4'd0;
              state_q  <= SEL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ds_frame_sched.sv
// tb_ds_frame_sched: randomized self-checking bench with a word-stream reference model.
// Rev 1.0
`default_nettype none

module tb_ds_frame_sched;
  import ds_pkg::*;

  localparam int NCH = 15;
  localparam int WPC = 32;

  logic              clk;
  logic              rst_n;
  logic              i_trig;
  logic [NCH*32-1:0] i_ch_data;
  logic [NCH-1:0]    i_ch_vld;
  logic [NCH-1:0]    o_ch_rdy;
  logic [35:0]       o_data;
  logic              o_vld;
  logic              i_rdy;
  logic [7:0]        i_mm_addr;
  logic              i_mm_wr;
  logic [31:0]       i_mm_wr_data;
  logic              i_mm_rd;
  logic [31:0]       o_mm_rd_data;

  ds_frame_sched #(
    .NCH          (NCH),
    .WORDS_PER_CH (WPC),
    .TMO_W        (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_trig       (i_trig),
    .i_ch_data    (i_ch_data),
    .i_ch_vld     (i_ch_vld),
    .o_ch_rdy     (o_ch_rdy),
    .o_data       (o_data),
    .o_vld        (o_vld),
    .i_rdy        (i_rdy),
    .i_mm_addr    (i_mm_addr),
    .i_mm_wr      (i_mm_wr),
    .i_mm_wr_data (i_mm_wr_data),
    .i_mm_rd      (i_mm_rd),
    .o_mm_rd_data (o_mm_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [35:0]  exp_q[$];
  int unsigned  src_cnt[NCH];
  int unsigned  exp_cnt[NCH];
  int unsigned  stop_limit[NCH];
  logic [31:0]  ch_seed[NCH];
  logic [NCH-1:0] pop;
  int           vld_pct;
  int           rdy_pct;
  int           n_cmp;
  int           n_err;
  int           tag_beats[16];
  bit           chk_rdy_zero;
  logic         prev_stall;
  logic [35:0]  prev_data;
  logic [31:0]  exp_frame;
  logic [31:0]  rd;

  function automatic logic [31:0] src_word(input int c, input int unsigned n);
    return ch_seed[c] ^ (n * 32'h9E37_79B1);
  endfunction

  task automatic check_val(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Channel sources: each presents its next word until the scheduler takes it.
  initial begin
    i_ch_vld  = '0;
    i_ch_data = '0;
    i_rdy     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (pop[c]) src_cnt[c]++;
        i_ch_data[c*32 +: 32] = src_word(c, src_cnt[c]);
        i_ch_vld[c] = (src_cnt[c] < stop_limit[c]) && ($urandom_range(99) < vld_pct);
      end
      i_rdy = ($urandom_range(99) < rdy_pct);
    end
  end

  // Stream monitor: values seen here are what the next rising edge acts on.
  initial begin
    pop        = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pop        = '0;
        prev_stall = 1'b0;
      end else begin
        pop = i_ch_vld & o_ch_rdy;
        check_val("rdy_onehot", {35'd0, $onehot0(o_ch_rdy)}, 36'd1);
        if (chk_rdy_zero) check_val("rdy_idle", 36'(o_ch_rdy), 36'd0);
        if (prev_stall && o_vld) check_val("hold", o_data, prev_data);
        if (o_vld && i_rdy) begin
          if (exp_q.size() == 0) begin
            check_val("extra_beat", 36'(exp_q.size()), 36'd1);
          end else begin
            check_val("beat", o_data, exp_q.pop_front());
            tag_beats[o_data[35:32]]++;
          end
        end
        prev_stall = o_vld & ~i_rdy;
        prev_data  = o_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mm_write(input logic [2:0] addr, input logic [31:0] data);
    i_mm_addr    = {5'd0, addr};
    i_mm_wr_data = data;
    i_mm_wr      = 1'b1;
    tick(1);
    i_mm_wr      = 1'b0;
  endtask

  task automatic mm_read(input logic [7:0] addr, output logic [31:0] data);
    i_mm_addr = addr;
    i_mm_rd   = 1'b1;
    tick(1);
    i_mm_rd   = 1'b0;
    data      = o_mm_rd_data;
  endtask

  task automatic pulse_trig();
    i_trig = 1'b1;
    tick(1);
    i_trig = 1'b0;
  endtask

  // Expected frame: enabled channels ascending, WPC words each, then the trailer.
  task automatic expect_frame(input logic [NCH-1:0] mask, input int pad_ch, input int pad_after);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < WPC; k++) begin
          if (c == pad_ch && k >= pad_after) begin
            exp_q.push_back({4'(c), 32'd0});
          end else begin
            exp_q.push_back({4'(c), src_word(c, exp_cnt[c])});
            exp_cnt[c]++;
          end
        end
      end
    end
    exp_q.push_back({TAG_TRAILER, exp_frame});
    exp_frame++;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_val("drained", 36'(exp_q.size()), 36'd0);
    exp_q.delete();
    tick(2);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] m;
    int             k;
    n_cmp        = 0;
    n_err        = 0;
    vld_pct      = 100;
    rdy_pct      = 100;
    chk_rdy_zero = 1'b0;
    exp_frame    = 32'd0;
    i_trig       = 1'b0;
    i_mm_addr    = 8'd0;
    i_mm_wr      = 1'b0;
    i_mm_wr_data = 32'd0;
    i_mm_rd      = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ch_seed[c]    = $urandom;
      src_cnt[c]    = 0;
      exp_cnt[c]    = 0;
      stop_limit[c] = 32'hFFFF_FFFF;
    end
    for (int t = 0; t < 16; t++) tag_beats[t] = 0;

    rst_n = 1'b0;
    tick(3);
    check_val("rst_vld", 36'(o_vld), 36'd0);
    check_val("rst_rdy", 36'(o_ch_rdy), 36'd0);
    check_val("rst_data", o_data, 36'd0);
    rst_n = 1'b1;
    tick(1);
    for (int a = 0; a < 7; a++) begin
      if (a != 5) begin
        mm_read(8'(a), rd);
        check_val($sformatf("rst_reg%0d", a), 36'(rd), 36'd0);
      end
    end

    // Two frames over channels 1 and 2.
    mm_write(REG_CH_MASK, 32'h0006);
    mm_write(REG_CTRL, 32'd1);
    repeat (2) begin
      expect_frame(15'h0006, -1, 0);
      pulse_trig();
      wait_drain(1000);
    end

    // Empty mask: trailers only, no channel ever readied.
    chk_rdy_zero = 1'b1;
    mm_write(REG_CH_MASK, 32'd0);
    repeat (3) begin
      expect_frame('0, -1, 0);
      pulse_trig();
      wait_drain(100);
    end
    chk_rdy_zero = 1'b0;

    // Backpressure on channel 3.
    rdy_pct = 50;
    mm_write(REG_CH_MASK, 32'h0008);
    tag_beats[3] = 0;
    expect_frame(15'h0008, -1, 0);
    pulse_trig();
    wait_drain(2000);
    check_val("ch3_beats", 36'(tag_beats[3]), 36'd32);
    rdy_pct = 100;

    // Channel 5 dries up after 7 words; the rest of its slot is padded.
    mm_write(REG_TIMEOUT, 32'd10);
    mm_write(REG_CH_MASK, 32'h0020);
    stop_limit[5] = src_cnt[5] + 7;
    expect_frame(15'h0020, 5, 7);
    pulse_trig();
    wait_drain(2000);
    mm_read({5'd0, REG_STATUS}, rd);
    check_val("underrun_cnt", 36'(rd[23:16]), 36'd1);
    check_val("status_idle", 36'(rd[4]), 36'd0);
    stop_limit[5] = 32'hFFFF_FFFF;
    mm_write(REG_TIMEOUT, 32'd0);

    // Triggers arriving during a frame are counted as missed.
    rdy_pct = 50;
    mm_write(REG_CH_MASK, 32'h0001);
    expect_frame(15'h0001, -1, 0);
    pulse_trig();
    tick(5);
    pulse_trig();
    tick(5);
    pulse_trig();
    wait_drain(2000);
    mm_read({5'd0, REG_STATUS}, rd);
    check_val("missed_trig", 36'(rd[31:24]), 36'd2);
    check_val("underrun_kept", 36'(rd[23:16]), 36'd1);
    mm_write(REG_STATUS_CLR, $urandom);
    mm_read({5'd0, REG_STATUS}, rd);
    check_val("status_clr", 36'(rd[31:16]), 36'd0);

    // Random masks, random source/sink throttling, mask rewritten mid-frame.
    vld_pct = 70;
    rdy_pct = 60;
    repeat (4) begin
      m = 15'($urandom);
      mm_write(REG_CH_MASK, 32'(m));
      expect_frame(m, -1, 0);
      pulse_trig();
      tick(3);
      mm_write(REG_CH_MASK, 32'(~m));
      wait_drain(8000);
    end
    mm_read({5'd0, REG_FRAME_CNT}, rd);
    check_val("frame_cnt", 36'(rd), 36'(exp_frame));

    // Free-running frames, then asynchronous reset in the middle of a channel.
    vld_pct = 100;
    rdy_pct = 100;
    mm_write(REG_CH_MASK, 32'h0002);
    mm_write(REG_CTRL, 32'd3);
    expect_frame(15'h0002, -1, 0);
    expect_frame(15'h0002, -1, 0);
    pulse_trig();
    k = 0;
    while (exp_q.size() > 16 && k < 500) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #3;
    check_val("pre_rst_vld", 36'(o_vld), 36'd1);
    check_val("pre_rst_tag", 36'(o_data[35:32]), 36'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_vld", 36'(o_vld), 36'd0);
    check_val("async_rst_rdy", 36'(o_ch_rdy), 36'd0);
    check_val("async_rst_data", o_data, 36'd0);
    tick(2);
    rst_n = 1'b1;
    exp_q.delete();
    exp_frame = 32'd0;
    tick(1);
    mm_read({5'd0, REG_FRAME_CNT}, rd);
    check_val("post_rst_frame_cnt", 36'(rd), 36'd0);
    mm_read({5'd0, REG_CTRL}, rd);
    check_val("post_rst_ctrl", 36'(rd), 36'd0);
    tick(5);
    check_val("post_rst_idle_vld", 36'(o_vld), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
